// File: rtl/serv_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serv_decode_pkg : RV32 opcode classes and decoded-bundle type        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package serv_decode_pkg;

  localparam logic [4:0] c_OP_LUI     = 5'b01101;
  localparam logic [4:0] c_OP_AUIPC   = 5'b00101;
  localparam logic [4:0] c_OP_JAL     = 5'b11011;
  localparam logic [4:0] c_OP_JALR    = 5'b11001;
  localparam logic [4:0] c_OP_BRANCH  = 5'b11000;
  localparam logic [4:0] c_OP_LOAD    = 5'b00000;
  localparam logic [4:0] c_OP_STORE   = 5'b01000;
  localparam logic [4:0] c_OP_OPIMM   = 5'b00100;
  localparam logic [4:0] c_OP_OP      = 5'b01100;
  localparam logic [4:0] c_OP_MISCMEM = 5'b00011;
  localparam logic [4:0] c_OP_SYSTEM  = 5'b11100;

  localparam logic [4:0] c_OP_LOADFP  = 5'b00001;
  localparam logic [4:0] c_OP_STOREFP = 5'b01001;
  localparam logic [4:0] c_OP_FMADD   = 5'b10000;
  localparam logic [4:0] c_OP_FMSUB   = 5'b10001;
  localparam logic [4:0] c_OP_FNMSUB  = 5'b10010;
  localparam logic [4:0] c_OP_FNMADD  = 5'b10011;
  localparam logic [4:0] c_OP_OPFP    = 5'b10100;

  // OP-FP funct5 values whose result lands in an integer register
  localparam logic [4:0] c_F5_FCMP    = 5'b10100;
  localparam logic [4:0] c_F5_FCVTW   = 5'b11000;
  localparam logic [4:0] c_F5_FMVXW   = 5'b11100;

  localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       rd_op;
    logic       mdu_op;
    logic       fpu_op;
    logic       illegal;
  } dec_t;

  function automatic logic is_rv32i(input logic [4:0] op);
    return op inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
                      c_OP_LOAD, c_OP_STORE, c_OP_OPIMM, c_OP_OP, c_OP_MISCMEM,
                      c_OP_SYSTEM};
  endfunction

  function automatic logic is_fp_op(input logic [4:0] op);
    return op inside {c_OP_LOADFP, c_OP_STOREFP, c_OP_FMADD, c_OP_FMSUB,
                      c_OP_FNMSUB, c_OP_FNMADD, c_OP_OPFP};
  endfunction

  function automatic logic writes_int_rd(input logic [4:0] op);
    return op inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_LOAD,
                      c_OP_OPIMM, c_OP_OP, c_OP_SYSTEM};
  endfunction

  function automatic logic is_rd_funct5(input logic [4:0] f5);
    return f5 inside {c_F5_FCMP, c_F5_FCVTW, c_F5_FMVXW};
  endfunction

endpackage
`default_nettype wire

// File: rtl/serv_decode_q_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serv_decode_q_if : fetch-push / decode-pop bus of the decode queue   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface serv_decode_q_if #(
  parameter int DEPTH = 4
) ();
  logic                     i_flush;
  logic                     i_ins_valid;
  logic [31:0]              i_ins;
  logic                     o_ins_ready;
  logic                     o_dec_valid;
  logic                     i_dec_ready;
  logic [4:0]               o_opcode;
  logic [2:0]               o_funct3;
  logic [4:0]               o_rd;
  logic                     o_rd_op;
  logic                     o_mdu_op;
  logic                     o_fpu_op;
  logic                     o_illegal;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output i_flush, i_ins_valid, i_ins, i_dec_ready,
    input  o_ins_ready, o_dec_valid, o_opcode, o_funct3, o_rd,
           o_rd_op, o_mdu_op, o_fpu_op, o_illegal, o_count
  );

  modport slave (
    input  i_flush, i_ins_valid, i_ins, i_dec_ready,
    output o_ins_ready, o_dec_valid, o_opcode, o_funct3, o_rd,
           o_rd_op, o_mdu_op, o_fpu_op, o_illegal, o_count
  );
endinterface
`default_nettype wire

// File: rtl/serv_decode_q_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serv_decode_q_dec : combinational RV32I(+M/F) instruction classifier |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module serv_decode_q_dec
  import serv_decode_pkg::*;
#(
  parameter int MDU = 1,
  parameter int FPU = 1
) (
  input  logic [31:0] i_ins,
  output dec_t        o_dec
);
  logic [4:0] w_op;
  logic       w_fp;
  logic       w_muldiv_off;
  logic       w_ill;
  logic       w_unused;

  assign w_op         = i_ins[6:2];
  assign w_fp         = (FPU != 0) && is_fp_op(w_op);
  // Without the M unit a mul/div encoding is reported rather than run as ALU op
  assign w_muldiv_off = (MDU == 0) && (w_op == c_OP_OP) && (i_ins[31:25] == c_FUNCT7_MULDIV);
  assign w_ill        = (i_ins[1:0] != 2'b11) || !(is_rv32i(w_op) || w_fp) || w_muldiv_off;
  assign w_unused     = &{1'b0, i_ins[24:15]};

  always_comb begin
    o_dec         = '0;
    o_dec.opcode  = w_op;
    o_dec.funct3  = i_ins[14:12];
    o_dec.rd      = i_ins[11:7];
    o_dec.illegal = w_ill;
    o_dec.mdu_op  = !w_ill && (MDU != 0) && (w_op == c_OP_OP) && i_ins[25];
    o_dec.fpu_op  = !w_ill && w_fp;
    o_dec.rd_op   = !w_ill && (writes_int_rd(w_op) ||
                    (w_fp && (w_op == c_OP_OPFP) && is_rd_funct5(i_ins[31:27])));
  end
endmodule
`default_nettype wire

// File: rtl/serv_decode_q.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serv_decode_q : instruction queue holding pre-decoded entries        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module serv_decode_q
  import serv_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MDU   = 1,
  parameter int FPU   = 1
) (
  input  logic           clk,
  input  logic           i_rst,
  serv_decode_q_if.slave bus
);
  localparam int             c_AW   = $clog2(DEPTH);
  localparam int             c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  dec_t              r_mem [DEPTH];
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_CW-1:0]   r_count;
  dec_t              w_dec;
  dec_t              w_head;
  logic              w_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;

  serv_decode_q_dec #(
    .MDU (MDU),
    .FPU (FPU)
  ) u_dec (
    .i_ins (bus.i_ins),
    .o_dec (w_dec)
  );

  assign w_ready = (r_count != c_FULL);
  assign w_valid = (r_count != '0);
  assign w_push  = bus.i_ins_valid & w_ready & ~bus.i_flush;
  assign w_pop   = w_valid & bus.i_dec_ready & ~bus.i_flush;

  always_ff @(posedge clk) begin
    if (i_rst || bus.i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define what is live
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  assign w_head          = r_mem[r_rptr];
  assign bus.o_ins_ready = w_ready;
  assign bus.o_dec_valid = w_valid;
  assign bus.o_count     = r_count;
  assign bus.o_opcode    = w_head.opcode;
  assign bus.o_funct3    = w_head.funct3;
  assign bus.o_rd        = w_head.rd;
  assign bus.o_rd_op     = w_head.rd_op;
  assign bus.o_mdu_op    = w_head.mdu_op;
  assign bus.o_fpu_op    = w_head.fpu_op;
  assign bus.o_illegal   = w_head.illegal;
endmodule
`default_nettype wire

// File: tb/tb_serv_decode_q.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serv_decode_q : random + directed bench for two decode queues     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serv_decode_q;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       rd_op;
    logic       mdu_op;
    logic       fpu_op;
    logic       illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        r_rst = 1'b1;
  logic        r_fl = 1'b0;
  logic        r_vld = 1'b0;
  logic [31:0] r_ins = '0;
  logic        r_rdy = 1'b0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  serv_decode_q_if #(.DEPTH(DEPTH)) bus1 ();
  serv_decode_q_if #(.DEPTH(DEPTH)) bus0 ();

  assign bus1.i_flush = r_fl;  assign bus1.i_ins_valid = r_vld;
  assign bus1.i_ins   = r_ins; assign bus1.i_dec_ready = r_rdy;
  assign bus0.i_flush = r_fl;  assign bus0.i_ins_valid = r_vld;
  assign bus0.i_ins   = r_ins; assign bus0.i_dec_ready = r_rdy;

  serv_decode_q #(.DEPTH(DEPTH), .MDU(1), .FPU(1)) u_full (.clk(clk), .i_rst(r_rst), .bus(bus1));
  serv_decode_q #(.DEPTH(DEPTH), .MDU(0), .FPU(0)) u_base (.clk(clk), .i_rst(r_rst), .bus(bus0));

  function automatic exp_t ref_dec(input logic [31:0] w, input bit mdu, input bit fpu);
    exp_t       e;
    logic [4:0] op = w[6:2];
    bit rv   = op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                          5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100};
    bit isfp = fpu && (op inside {5'b00001, 5'b01001, 5'b10000, 5'b10001, 5'b10010,
                                  5'b10011, 5'b10100});
    e.opcode  = op;
    e.funct3  = w[14:12];
    e.rd      = w[11:7];
    e.illegal = (w[1:0] != 2'b11) || !(rv || isfp) ||
                (!mdu && op == 5'b01100 && w[31:25] == 7'b0000001);
    e.mdu_op  = !e.illegal && mdu && op == 5'b01100 && w[25];
    e.fpu_op  = !e.illegal && isfp;
    e.rd_op   = !e.illegal &&
                ((op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                             5'b00100, 5'b01100, 5'b11100}) ||
                 (op == 5'b10100 && (w[31:27] inside {5'b10100, 5'b11000, 5'b11100})));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input logic [2:0] cnt, input logic rdy, input logic vld,
                     input exp_t bund, input bit mdu, input bit fpu);
    int n = q.size();
    chk({nm, ".count"}, 32'(cnt), n);
    chk({nm, ".ins_ready"}, 32'(rdy), 32'(n != DEPTH));
    chk({nm, ".dec_valid"}, 32'(vld), 32'(n != 0));
    if (n != 0) chk({nm, ".bundle"}, 32'(bund), 32'(ref_dec(q[0], mdu, fpu)));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("full", bus1.o_count, bus1.o_ins_ready, bus1.o_dec_valid,
          {bus1.o_opcode, bus1.o_funct3, bus1.o_rd, bus1.o_rd_op, bus1.o_mdu_op,
           bus1.o_fpu_op, bus1.o_illegal}, 1'b1, 1'b1);
      cmp("base", bus0.o_count, bus0.o_ins_ready, bus0.o_dec_valid,
          {bus0.o_opcode, bus0.o_funct3, bus0.o_rd, bus0.o_rd_op, bus0.o_mdu_op,
           bus0.o_fpu_op, bus0.o_illegal}, 1'b0, 1'b0);
    end
  end

  // One clock: drive inputs, then advance the queue model at the edge
  task automatic cyc(input logic v, input logic [31:0] w, input logic rd,
                     input logic fl, input logic rs);
    bit push, pop;
    @(negedge clk);
    #1;
    r_vld = v; r_ins = w; r_rdy = rd; r_fl = fl; r_rst = rs;
    @(posedge clk);
    if (rs || fl) q.delete();
    else begin
      push = v && (q.size() != DEPTH);
      pop  = rd && (q.size() != 0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(w);
    end
    #2;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] ops [18] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                             5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100, 5'b00001,
                             5'b01001, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100};
    logic [4:0] f5s [3] = '{5'b10100, 5'b11000, 5'b11100};
    logic [31:0] w = $urandom;
    int idx = $urandom_range(0, 21);
    if (idx < 18) w[6:2] = ops[idx];
    if ($urandom_range(0, 15) != 0) w[1:0] = 2'b11;
    if (w[6:2] == 5'b01100 && $urandom_range(0, 1) == 1) w[31:25] = 7'b0000001;
    if (w[6:2] == 5'b10100 && $urandom_range(0, 1) == 1) w[31:27] = f5s[$urandom_range(0, 2)];
    return w;
  endfunction

  initial begin
    cyc(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cyc(1, 32'h00A00093, 1, 1, 1);
    chk("rst.count", 32'(bus1.o_count), 0);
    chk("rst.ready", 32'(bus1.o_ins_ready), 1);
    chk("rst.valid", 32'(bus0.o_dec_valid), 0);

    cyc(1, 32'h00A00093, 0, 0, 0);
    chk("addi.valid", 32'(bus1.o_dec_valid), 1);
    chk("addi.opcode", 32'(bus1.o_opcode), 32'h04);
    chk("addi.funct3", 32'(bus1.o_funct3), 0);
    chk("addi.rd", 32'(bus1.o_rd), 1);
    chk("addi.rd_op", 32'(bus1.o_rd_op), 1);
    chk("addi.illegal", 32'(bus0.o_illegal), 0);
    cyc(0, 0, 1, 0, 0);

    cyc(1, 32'h02208033, 0, 0, 0);
    chk("mul.mdu_op", 32'(bus1.o_mdu_op), 1);
    chk("mul.rd_op", 32'(bus1.o_rd_op), 1);
    chk("mul.base_illegal", 32'(bus0.o_illegal), 1);
    chk("mul.base_mdu_op", 32'(bus0.o_mdu_op), 0);
    cyc(0, 0, 1, 0, 0);

    cyc(1, 32'h003100D3, 0, 0, 0);
    chk("fadd.fpu_op", 32'(bus1.o_fpu_op), 1);
    chk("fadd.rd_op", 32'(bus1.o_rd_op), 0);
    chk("fadd.illegal", 32'(bus1.o_illegal), 0);
    chk("fadd.base_illegal", 32'(bus0.o_illegal), 1);
    cyc(0, 0, 1, 0, 0);

    // Pointers sit at 3 here, so filling four entries wraps them
    for (int i = 0; i < 4; i++) cyc(1, {20'h0, 5'(10 + i), 7'h13}, 0, 0, 0);
    chk("full.count", 32'(bus1.o_count), 4);
    chk("full.ready", 32'(bus1.o_ins_ready), 0);
    cyc(1, {20'h0, 5'd31, 7'h13}, 0, 0, 0);
    chk("drop.count", 32'(bus1.o_count), 4);
    chk("drop.head", 32'(bus1.o_rd), 10);
    cyc(0, 0, 1, 0, 0);
    chk("pop1.count", 32'(bus1.o_count), 3);
    chk("pop1.ready", 32'(bus1.o_ins_ready), 1);
    for (int i = 1; i < 4; i++) begin
      chk("wrap.order", 32'(bus1.o_rd), 32'(10 + i));
      cyc(0, 0, 1, 0, 0);
    end
    chk("drain.valid", 32'(bus1.o_dec_valid), 0);

    cyc(1, 32'h00A00093, 0, 0, 0);
    cyc(1, 32'h00A00093, 0, 0, 0);
    cyc(1, 32'h00A00093, 1, 1, 0);
    chk("flush.count", 32'(bus1.o_count), 0);
    chk("flush.valid", 32'(bus1.o_dec_valid), 0);

    cyc(1, 32'h02208033, 0, 0, 0);
    cyc(1, 32'h02208033, 0, 0, 0);
    cyc(1, 32'h02208033, 1, 0, 1);
    chk("midrst.count", 32'(bus0.o_count), 0);
    chk("midrst.valid", 32'(bus0.o_dec_valid), 0);
    cyc(1, 32'h00A00093, 0, 0, 0);
    chk("postrst.count", 32'(bus1.o_count), 1);
    chk("postrst.rd", 32'(bus1.o_rd), 1);
    chk("postrst.rd_op", 32'(bus1.o_rd_op), 1);

    repeat (3000) begin
      cyc($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serv_decode_q.md
SERV_DECODE_Q -- requirements
Module: serv_decode_q

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, >= 2.
REQ-002 Parameter MDU, default 1: 1 enables M-extension decode (mul/div).
REQ-003 Parameter FPU, default 1: 1 enables F-extension opcode decode.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset; synchronous, active-high.
REQ-006 i_flush  input  1  discard all queued entries (taken branch/trap).
REQ-007 i_ins_valid  input  1  fetched instruction offered.
REQ-008 i_ins  input  32  raw instruction word.
REQ-009 o_ins_ready  output  1  queue accepts a push this cycle.
REQ-010 o_dec_valid  output  1  head entry holds a decoded instruction.
REQ-011 i_dec_ready  input  1  core consumes the head entry.
REQ-012 o_opcode  output  5  head instruction bits [6:2].
REQ-013 o_funct3  output  3  head instruction bits [14:12].
REQ-014 o_rd  output  5  head instruction bits [11:7].
REQ-015 o_rd_op  output  1  head writes an integer rd.
REQ-016 o_mdu_op  output  1  head is an M-extension op.
REQ-017 o_fpu_op  output  1  head is an F-extension op.
REQ-018 o_illegal  output  1  head is unsupported/illegal.
REQ-019 o_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 Push occurs when i_ins_valid & o_ins_ready & !i_flush; pop occurs when o_dec_valid & i_dec_ready & !i_flush.
REQ-021 o_ins_ready = (o_count != DEPTH); no full-queue bypass; a push offered while full is dropped and the source holds it.
REQ-022 o_dec_valid = (o_count != 0); push into empty queue gives o_dec_valid=1 the following cycle (latency 1); no same-cycle bypass.
REQ-023 Decode is performed at push; each entry stores the decoded bundle; head outputs read the entry at the read pointer directly.
REQ-024 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-025 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 i_flush: next cycle count=0, both pointers=0; a simultaneous push or pop is ignored.
REQ-027 o_mdu_op = MDU & opcode==01100 & ins[25].
REQ-028 o_fpu_op = FPU & opcode in {00001, 01001, 10000, 10001, 10010, 10011, 10100}.
REQ-029 o_rd_op = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM; also for OP-FP with funct5 (ins[31:27]) in {10100, 11000, 11100}; otherwise 0.
REQ-030 o_illegal = 1 when:
- ins[1:0] != 11; or
- opcode not in the RV32I set {01101, 00101, 11011, 11001, 11000, 00000, 01000, 00100, 01100, 00011, 11100} and not an enabled FPU opcode; or
- MDU=0 and opcode==01100 and ins[31:25]==0000001.
REQ-031 When o_illegal=1, o_mdu_op, o_fpu_op and o_rd_op are 0.
REQ-032 When o_dec_valid=0, decoded outputs are don't-care; the bench checks them only when o_dec_valid=1.

Reset
REQ-033 i_rst=1 sets count=0, both pointers=0, o_dec_valid=0, o_ins_ready=1, o_count=0 on the next edge; i_rst overrides i_flush, push and pop.
REQ-034 Entry storage is not reset.
REQ-035 Reset asserted mid-stream discards all entries; the first push after deassertion is decoded normally.

Structure
REQ-036 Opcode constants (RV32I, FP classes) and the funct5 rd-writing list live in a shared package, serv_decode_pkg.
REQ-037 Pure combinational decode is one sub-module, serv_decode_q_dec (32-bit word in, bundle out, MDU/FPU params); the queue instantiates it on the push path.

Verification
REQ-038 Push 0x00A00093 into empty queue -> next cycle o_dec_valid=1, opcode=00100, funct3=000, rd=1, rd_op=1, illegal=0.
REQ-039 Push 0x02208033 -> MDU=1: mdu_op=1, rd_op=1; MDU=0: illegal=1, mdu_op=0.
REQ-040 Push 0x003100D3 (fadd.s) -> FPU=1: fpu_op=1, rd_op=0, illegal=0; FPU=0: illegal=1.
REQ-041 DEPTH=4, i_dec_ready=0, push 4 words -> o_count=4, o_ins_ready=0; fifth push dropped; one pop -> o_count=3, o_ins_ready=1; FIFO order preserved across pointer wrap.
REQ-042 Queue at 2 entries, i_flush with push and pop in the same cycle -> next cycle o_count=0, o_dec_valid=0; i_rst mid-stream -> same result.
